// File: rtl/crop_ctrl.sv
// crop_ctrl: raster tracker and crop-window controller for the crop datapath.
// Tracks (x,y) over an IN_ROWS x IN_COLS stream, flags pixels inside the
// active window, and swaps in a validated pending window only at frame
// boundaries so a frame never mixes two windows.
module crop_ctrl #(
    parameter int IN_ROWS  = 40,
    parameter int IN_COLS  = 40,
    parameter int DEF_Y1   = 10,
    parameter int DEF_X1   = 10,
    parameter int DEF_ROWS = 20,
    parameter int DEF_COLS = 20,
    localparam int CW = $clog2(IN_COLS + 1),
    localparam int RW = $clog2(IN_ROWS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          out_ready,
    input  logic          abort,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [RW-1:0] cfg_y1,
    input  logic [RW-1:0] cfg_rows,
    input  logic [CW-1:0] cfg_x1,
    input  logic [CW-1:0] cfg_cols,
    output logic          cfg_err,
    output logic [RW-1:0] act_y1,
    output logic [RW-1:0] act_rows,
    output logic [CW-1:0] act_x1,
    output logic [CW-1:0] act_cols,
    output logic [CW-1:0] x,
    output logic [RW-1:0] y,
    output logic          keep,
    output logic          sof,
    output logic          eof,
    output logic          win_last,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_x;
    logic [RW-1:0] r_y;
    logic [15:0]   r_frame_cnt;
    logic [RW-1:0] r_act_y1, r_act_rows, r_pend_y1, r_pend_rows;
    logic [CW-1:0] r_act_x1, r_act_cols, r_pend_x1, r_pend_cols;
    logic          r_pend_valid;
    logic          r_cfg_err;

    logic          w_beat, w_col_last, w_row_last, w_last_px;
    logic          w_hs, w_bad, w_apply;
    logic [RW:0]   w_cfg_y_end, w_act_y_end, w_y_ext;
    logic [CW:0]   w_cfg_x_end, w_act_x_end, w_x_ext;
    logic          w_in_y, w_in_x;

    // Beat qualification, frame position and window-membership decode.
    always_comb begin
        w_beat      = in_valid & out_ready & ~abort;
        w_col_last  = (r_x == CW'(IN_COLS - 1));
        w_row_last  = (r_y == RW'(IN_ROWS - 1));
        w_last_px   = w_col_last & w_row_last;
        // Sums are one bit wider than the operands so they cannot wrap.
        w_cfg_y_end = {1'b0, cfg_y1} + {1'b0, cfg_rows};
        w_cfg_x_end = {1'b0, cfg_x1} + {1'b0, cfg_cols};
        w_act_y_end = {1'b0, r_act_y1} + {1'b0, r_act_rows};
        w_act_x_end = {1'b0, r_act_x1} + {1'b0, r_act_cols};
        w_y_ext     = {1'b0, r_y};
        w_x_ext     = {1'b0, r_x};
        w_in_y      = (r_y >= r_act_y1) & (w_y_ext < w_act_y_end);
        w_in_x      = (r_x >= r_act_x1) & (w_x_ext < w_act_x_end);
        w_bad       = (cfg_rows == '0) | (cfg_cols == '0) |
                      (w_cfg_y_end > (RW + 1)'(IN_ROWS)) |
                      (w_cfg_x_end > (CW + 1)'(IN_COLS));
        // The handshake can only happen with no pending entry, so a new
        // window is never applied on the edge it is accepted.
        w_hs        = cfg_valid & ~r_pend_valid;
        w_apply     = (w_beat & w_last_px) | abort | ((r_state == S_IDLE) & ~w_beat);
    end

    // Next-state logic: abort forces IDLE, the last-pixel beat ends a frame.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else if (w_beat) begin
            // A 1x1 frame starts and ends on the same beat and stays IDLE.
            if (w_last_px) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_ACTIVE;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Raster counters and completed-frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= 16'd0;
        end else if (abort) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_beat) begin
            if (w_col_last) begin
                r_x <= '0;
                if (w_row_last) begin
                    r_y         <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_y <= r_y + RW'(1);
                end
            end else begin
                r_x <= r_x + CW'(1);
            end
        end
    end

    // Pending shadow capture, rejection pulse, and frame-boundary apply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_y1     <= RW'(DEF_Y1);
            r_act_x1     <= CW'(DEF_X1);
            r_act_rows   <= RW'(DEF_ROWS);
            r_act_cols   <= CW'(DEF_COLS);
            r_pend_y1    <= '0;
            r_pend_x1    <= '0;
            r_pend_rows  <= '0;
            r_pend_cols  <= '0;
            r_pend_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_hs & w_bad;
            if (w_hs & ~w_bad) begin
                r_pend_y1    <= cfg_y1;
                r_pend_x1    <= cfg_x1;
                r_pend_rows  <= cfg_rows;
                r_pend_cols  <= cfg_cols;
                r_pend_valid <= 1'b1;
            end else if (r_pend_valid & w_apply) begin
                r_act_y1     <= r_pend_y1;
                r_act_x1     <= r_pend_x1;
                r_act_rows   <= r_pend_rows;
                r_act_cols   <= r_pend_cols;
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign cfg_ready = ~r_pend_valid;
    assign cfg_err   = r_cfg_err;
    assign act_y1    = r_act_y1;
    assign act_x1    = r_act_x1;
    assign act_rows  = r_act_rows;
    assign act_cols  = r_act_cols;
    assign x         = r_x;
    assign y         = r_y;
    assign busy      = (r_state == S_ACTIVE);
    assign frame_cnt = r_frame_cnt;
    assign keep      = w_beat & w_in_y & w_in_x;
    assign sof       = w_beat & (r_x == '0) & (r_y == '0);
    assign eof       = w_beat & w_last_px;
    assign win_last  = w_beat & ((w_y_ext + (RW + 1)'(1)) == w_act_y_end) &
                       ((w_x_ext + (CW + 1)'(1)) == w_act_x_end);

endmodule

// File: tb/tb_crop_ctrl.sv
// Directed testbench for crop_ctrl with a 40x40 frame and default 10..29 window.
module tb_crop_ctrl;
    localparam int CW = 6;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
    logic [RW-1:0] cfg_y1 = '0, cfg_rows = '0;
    logic [CW-1:0] cfg_x1 = '0, cfg_cols = '0;
    logic          cfg_ready, cfg_err, keep, sof, eof, win_last, busy;
    logic [RW-1:0] act_y1, act_rows, y;
    logic [CW-1:0] act_x1, act_cols, x;
    logic [15:0]   frame_cnt;

    int n_checks = 0;
    int n_fail = 0;

    crop_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .out_ready(out_ready),
        .abort(abort), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_y1(cfg_y1), .cfg_rows(cfg_rows), .cfg_x1(cfg_x1), .cfg_cols(cfg_cols),
        .cfg_err(cfg_err), .act_y1(act_y1), .act_rows(act_rows), .act_x1(act_x1),
        .act_cols(act_cols), .x(x), .y(y), .keep(keep), .sof(sof), .eof(eof),
        .win_last(win_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++; if ({x, y} !== 12'd0) begin n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y); end
        n_checks++; if ({busy, cfg_err, keep, sof, eof, win_last} !== 6'b000000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {busy, cfg_err, keep, sof, eof, win_last}); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        n_checks++; if ({act_y1, act_x1, act_rows, act_cols} !== {6'd10, 6'd10, 6'd20, 6'd20}) begin n_fail++; $display("FAIL reset_act: got %0d %0d %0d %0d expected 10 10 20 20", act_y1, act_x1, act_rows, act_cols); end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        int keeps = 0, errs = 0, sofs = 0;
        int fkx = -1, fky = -1, wlx = -1, wly = -1, efx = -1, efy = -1;
        bit ek;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; #1;
            ek = (i / 40 >= 10) && (i / 40 < 30) && (i % 40 >= 10) && (i % 40 < 30);
            if (x !== CW'(i % 40) || y !== RW'(i / 40) || keep !== ek) errs++;
            if (keep === 1'b1) begin keeps++; if (fkx < 0) begin fkx = int'(x); fky = int'(y); end end
            if (win_last === 1'b1) begin wlx = int'(x); wly = int'(y); end
            if (eof === 1'b1) begin efx = int'(x); efy = int'(y); end
            if (sof === 1'b1) sofs++;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL frame_raster: got %0d bad beats expected 0", errs); end
        n_checks++; if (keeps !== 400) begin n_fail++; $display("FAIL frame_keeps: got %0d expected 400", keeps); end
        n_checks++; if (fkx !== 10 || fky !== 10) begin n_fail++; $display("FAIL frame_first_keep: got (%0d,%0d) expected (10,10)", fkx, fky); end
        n_checks++; if (wlx !== 29 || wly !== 29) begin n_fail++; $display("FAIL frame_win_last: got (%0d,%0d) expected (29,29)", wlx, wly); end
        n_checks++; if (efx !== 39 || efy !== 39) begin n_fail++; $display("FAIL frame_eof: got (%0d,%0d) expected (39,39)", efx, efy); end
        n_checks++; if (sofs !== 1) begin n_fail++; $display("FAIL frame_sof_count: got %0d expected 1", sofs); end
        n_checks++; if (frame_cnt !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL frame_end: got cnt=%0d busy=%b expected 1 0", frame_cnt, busy); end
    endtask

    task automatic test_ready_toggle();
        int b = 0, keeps = 0, errs = 0;
        bit ek;
        for (int c = 0; c < 3200; c++) begin
            @(negedge clk); in_valid = 1'b1; out_ready = (c % 2 == 0); #1;
            ek = out_ready && (b / 40 >= 10) && (b / 40 < 30) && (b % 40 >= 10) && (b % 40 < 30);
            if (x !== CW'(b % 40) || y !== RW'((b / 40) % 40) || keep !== ek) errs++;
            if (keep === 1'b1) keeps++;
            if (out_ready) b++;
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL toggle_frozen: got %0d bad cycles expected 0", errs); end
        n_checks++; if (keeps !== 400) begin n_fail++; $display("FAIL toggle_keeps: got %0d expected 400", keeps); end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL toggle_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_cfg_pending();
        int keeps1 = 0, keeps2 = 0, errs = 0;
        bit ek;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk); in_valid = 1'b1; out_ready = 1'b1;
            cfg_valid = (i == 100); cfg_y1 = 6'd0; cfg_x1 = 6'd0; cfg_rows = 6'd5; cfg_cols = 6'd5; #1;
            if (i == 101) begin
                n_checks++; if (cfg_ready !== 1'b0 || act_y1 !== 6'd10) begin n_fail++; $display("FAIL pend_held: got ready=%b act_y1=%0d expected 0 10", cfg_ready, act_y1); end
            end
            ek = (i / 40 >= 10) && (i / 40 < 30) && (i % 40 >= 10) && (i % 40 < 30);
            if (keep !== ek) errs++;
            if (keep === 1'b1) keeps1++;
        end
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk); cfg_valid = 1'b0; #1;
            ek = (i / 40 < 5) && (i % 40 < 5);
            if (keep !== ek) errs++;
            if (keep === 1'b1) keeps2++;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        n_checks++; if (keeps1 !== 400) begin n_fail++; $display("FAIL pend_frame1_keeps: got %0d expected 400", keeps1); end
        n_checks++; if (keeps2 !== 25) begin n_fail++; $display("FAIL pend_frame2_keeps: got %0d expected 25", keeps2); end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL pend_keep_map: got %0d bad beats expected 0", errs); end
        n_checks++; if ({act_y1, act_x1, act_rows, act_cols} !== {6'd0, 6'd0, 6'd5, 6'd5} || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL pend_applied: got %0d %0d %0d %0d ready=%b expected 0 0 5 5 1", act_y1, act_x1, act_rows, act_cols, cfg_ready); end
        n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL pend_frame_cnt: got %0d expected 4", frame_cnt); end
    endtask

    task automatic test_cfg_err();
        @(negedge clk); cfg_valid = 1'b1; cfg_y1 = 6'd0; cfg_rows = 6'd5; cfg_x1 = 6'd30; cfg_cols = 6'd20;
        @(negedge clk); cfg_valid = 1'b0; #1;
        n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_xrange_pulse: got %b expected 1", cfg_err); end
        n_checks++; if (act_x1 !== 6'd0 || act_cols !== 6'd5 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_xrange_state: got x1=%0d cols=%0d ready=%b expected 0 5 1", act_x1, act_cols, cfg_ready); end
        @(negedge clk); #1;
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", cfg_err); end
        cfg_valid = 1'b1; cfg_y1 = 6'd1; cfg_rows = 6'd0; cfg_x1 = 6'd1; cfg_cols = 6'd3;
        @(negedge clk); cfg_valid = 1'b0; #1;
        n_checks++; if (cfg_err !== 1'b1 || act_rows !== 6'd5 || act_y1 !== 6'd0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_rows0: got err=%b rows=%0d y1=%0d ready=%b expected 1 5 0 1", cfg_err, act_rows, act_y1, cfg_ready); end
    endtask

    task automatic test_idle_apply();
        @(negedge clk); cfg_valid = 1'b1; cfg_y1 = 6'd35; cfg_rows = 6'd5; cfg_x1 = 6'd35; cfg_cols = 6'd5; #1;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL apply_ready_before: got %b expected 1", cfg_ready); end
        @(negedge clk); cfg_valid = 1'b0; #1;
        n_checks++; if (cfg_ready !== 1'b0 || act_x1 !== 6'd0 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL apply_pending: got ready=%b x1=%0d err=%b expected 0 0 0", cfg_ready, act_x1, cfg_err); end
        @(negedge clk); #1;
        n_checks++; if ({act_y1, act_x1, act_rows, act_cols} !== {6'd35, 6'd35, 6'd5, 6'd5} || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL apply_active: got %0d %0d %0d %0d ready=%b expected 35 35 5 5 1", act_y1, act_x1, act_rows, act_cols, cfg_ready); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); in_valid = 1'b1; out_ready = 1'b1;
            cfg_valid = (i == 10); cfg_y1 = 6'd2; cfg_x1 = 6'd3; cfg_rows = 6'd4; cfg_cols = 6'd6;
        end
        @(negedge clk); cfg_valid = 1'b0; abort = 1'b1; #1;
        n_checks++; if (x !== 6'd20 || y !== 6'd12 || busy !== 1'b1 || keep !== 1'b0 || act_x1 !== 6'd35) begin n_fail++; $display("FAIL abort_before: got x=%0d y=%0d busy=%b keep=%b x1=%0d expected 20 12 1 0 35", x, y, busy, keep, act_x1); end
        @(negedge clk); abort = 1'b0; #1;
        n_checks++; if (x !== 6'd0 || y !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_counters: got x=%0d y=%0d busy=%b expected 0 0 0", x, y, busy); end
        n_checks++; if ({act_y1, act_x1, act_rows, act_cols} !== {6'd2, 6'd3, 6'd4, 6'd6} || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL abort_apply: got %0d %0d %0d %0d ready=%b expected 2 3 4 6 1", act_y1, act_x1, act_rows, act_cols, cfg_ready); end
        n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL abort_frame_cnt: got %0d expected 4", frame_cnt); end
        n_checks++; if (sof !== 1'b1 || keep !== 1'b0) begin n_fail++; $display("FAIL abort_next_sof: got sof=%b keep=%b expected 1 0", sof, keep); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); in_valid = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        n_checks++; if (busy !== 1'b1 || x !== 6'd11 || y !== 6'd1) begin n_fail++; $display("FAIL rst_pre: got busy=%b x=%0d y=%0d expected 1 11 1", busy, x, y); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (x !== 6'd0 || y !== 6'd0 || busy !== 1'b0 || frame_cnt !== 16'd0 || keep !== 1'b0) begin n_fail++; $display("FAIL rst_async: got x=%0d y=%0d busy=%b cnt=%0d keep=%b expected 0 0 0 0 0", x, y, busy, frame_cnt, keep); end
        n_checks++; if ({act_y1, act_x1, act_rows, act_cols} !== {6'd10, 6'd10, 6'd20, 6'd20} || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_act: got %0d %0d %0d %0d ready=%b expected 10 10 20 20 1", act_y1, act_x1, act_rows, act_cols, cfg_ready); end
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_ready_toggle();
        test_cfg_pending();
        test_cfg_err();
        test_idle_apply();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/crop_ctrl.md
# crop_ctrl

Sequencing and configuration controller for the crop filter datapath. It tracks raster position over an IN_ROWS×IN_COLS camera stream and marks each pixel as inside or outside a runtime-programmable crop window. It also flags frame and window boundaries. New window settings are accepted through a valid/ready port and are applied only at frame boundaries, so a frame is never cropped with a mix of two windows. It sits between the camera grabber handshake and the crop datapath, which registers pixels when `keep` is high.

## Interface
- `IN_ROWS`, 40, input frame height (≥1)
- `IN_COLS`, 40, input frame width (≥1)
- `DEF_Y1`, 10, reset window top row
- `DEF_X1`, 10, reset window left column
- `DEF_ROWS`, 20, reset window height
- `DEF_COLS`, 20, reset window width
- Width rules:
  - CW = $clog2(IN_COLS+1)
  - RW = $clog2(IN_ROWS+1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; all state to reset values immediately
- `in_valid`  in  1  upstream pixel present
- `out_ready`  in  1  downstream can take a pixel
- `abort`  in  1  synchronous frame abort
- `cfg_valid`  in  1  new window offered
- `cfg_ready`  out  1  new window can be accepted
- `cfg_y1`, `cfg_rows`  in  RW  window top / height
- `cfg_x1`, `cfg_cols`  in  CW  window left / width
- `cfg_err`  out  1  one-cycle pulse: offered window rejected
- `act_y1`, `act_rows`  out  RW  active window
- `act_x1`, `act_cols`  out  CW  active window
- `x`  out  CW  current column
- `y`  out  RW  current row
- `keep`  out  1  current beat lies inside the window
- `sof`  out  1  current beat is pixel (0,0)
- `eof`  out  1  current beat is the last pixel of the frame
- `win_last`  out  1  current beat is the window's bottom-right pixel
- `busy`  out  1  state == ACTIVE
- `frame_cnt`  out  16  completed frames, wraps at 65535→0

## Operation
- Beat:
  - beat = in_valid & out_ready & ~abort.
  - Counters advance only on a beat.
- Raster counters:
  - `x` increments on each beat.
  - At x==IN_COLS-1, `x` wraps to 0 and `y` increments.
  - At the last pixel (x==IN_COLS-1, y==IN_ROWS-1), both counters wrap to 0.
- FSM:
  - IDLE: counters at 0. A beat moves to ACTIVE, except when IN_ROWS·IN_COLS==1, which stays in IDLE.
  - ACTIVE: a beat on the last pixel moves to IDLE and increments `frame_cnt`.
  - `abort` from any state: counters to 0, state to IDLE. `frame_cnt` is unchanged.
- Outputs `keep`, `sof`, `eof`, `win_last` are combinational, qualified by beat, and computed from registered counters and the active window:
  - keep = beat & (y ≥ act_y1) & (y < act_y1+act_rows) & (x ≥ act_x1) & (x < act_x1+act_cols).
  - Comparisons use widths RW+1 and CW+1, so sums never overflow.
- Configuration:
  - Two-entry arrangement: active registers plus one pending shadow.
  - cfg_ready = ~pending_valid.
  - Handshake on cfg_valid & cfg_ready.
- Validation at handshake. A window is rejected (cfg_err pulses the next cycle, nothing is stored) when any of:
  - cfg_rows==0 or cfg_cols==0;
  - cfg_y1+cfg_rows > IN_ROWS;
  - cfg_x1+cfg_cols > IN_COLS.
- Application of the pending window to the active registers, clearing `pending_valid`, happens on any of:
  - the edge of a last-pixel beat;
  - the edge of `abort`;
  - any edge with state==IDLE and no beat.
- Simultaneous events:
  - A handshake in the same cycle as an application point: the new window becomes pending and is not applied that edge.
  - A first beat of a frame in IDLE uses the current active window. A pending window then waits for the frame end.
- Reset values:
  - act_* = DEF_*; pending cleared; x=y=0; IDLE; frame_cnt=0.
  - cfg_ready=1, cfg_err=0, busy=0.
  - keep/sof/eof/win_last = 0 because beat is low in reset.

## Timing
- keep/sof/eof/win_last: zero latency, same cycle as the beat. The datapath samples the pixel on that edge.
- cfg_err: one cycle after the handshake edge.
- A window accepted while IDLE with no beat is active 2 cycles after cfg_valid is asserted: handshake edge, then apply edge.
- cfg_ready falls the cycle after acceptance and rises the cycle after application.
- Reset asserted mid-frame: counters clear asynchronously. The frame in progress is discarded and not counted.

## Test plan
- Defaults, 1600 continuous beats (out_ready=1) -> keep high on exactly 400 beats, first at (x=10,y=10), win_last at (29,29), eof at (39,39); frame_cnt=1; busy low afterwards.
- out_ready toggled every other cycle -> counters frozen on non-beat cycles; same 400 keeps over 1600 beats.
- Offer y1=0,x1=0,rows=5,cols=5 at beat 100 -> accepted, pending, cfg_ready=0. Frame 1 still keeps the 10..29 window. Frame 2 keeps 25 pixels, rows/cols 0..4.
- Offer x1=30,cols=20 -> cfg_err pulse the next cycle; act_* unchanged; cfg_ready stays 1. Same for rows=0.
- abort at beat 500 with a pending config -> x=y=0, IDLE, new window active, frame_cnt unchanged. The next beat asserts sof.
- Reset asserted mid-frame (asynchronously, between edges) -> outputs return to reset values immediately, frame_cnt=0, act_* = defaults.
